aes_decrypt_iter: RTL

Iterative, handshaked AES inverse-cipher engine, parametrised for AES-128/192/256 via NK. It supersedes the fully unrolled decryptor for area-constrained integrations. Key expansion runs on-chip one word per cycle into a round-key register file. The round datapath is reused, one round per cycle. It sits between the block-input FIFO and the plaintext consumer, using valid/ready streams on both sides.

---
 rtl/aes_pkg.sv | 82 ++++++++
 rtl/aes_dec_round.sv | 51 +++++
 rtl/aes_decrypt_iter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative inverse cipher.
// S-boxes are computed from the field inverse plus affine map.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        S_NOKEY,
        S_EXPAND,
        S_IDLE,
        S_ROUND,
        S_HOLD
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = ginv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        unique case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_i is set.
module aes_dec_round
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] st_o
);

    logic [127:0] ark;
    logic [127:0] mc;
    logic [7:0]   sb;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        ark = '0;
        sb  = '0;
        // byte k sits at row k%4, column k/4; row r rotates right by r
        for (int k = 0; k < 16; k++) begin
            sb = inv_sbox(st_i[127 - 8 * (4 * (((k / 4) - (k % 4)) & 3) + (k % 4)) -: 8]);
            ark[127 - 8 * k -: 8] = sb ^ rk_i[127 - 8 * k -: 8];
        end
    end

    always_comb begin
        mc = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127 - 32 * c -: 8];
            a1 = ark[119 - 32 * c -: 8];
            a2 = ark[111 - 32 * c -: 8];
            a3 = ark[103 - 32 * c -: 8];
            mc[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                                  ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mc[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                                  ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mc[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                                  ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mc[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                                  ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    assign st_o = last_i ? ark : mc;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 inverse cipher with on-chip key expansion.
// Define AES_DEC_CBC_EN to add the CBC chaining register and its ports.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6,
    parameter int NW = 4 * (NR + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [32*NK-1:0]  key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
`ifdef AES_DEC_CBC_EN
    input  logic              iv_load,
    input  logic [127:0]      iv_in,
    input  logic              cbc_mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data
);

    localparam int IW = $clog2(NW);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_decrypt_iter: NK must be 4, 6 or 8");
    end
    if (NR != NK + 6 || NW != 4 * (NR + 1)) begin : g_bad_nr
        $error("aes_decrypt_iter: NR/NW are derived from NK");
    end

    state_e        state_q, state_d;
    logic [31:0]   w_q [NW];
    logic [IW-1:0] i_q;
    logic [2:0]    m_q;
    logic [3:0]    rc_q;
    logic [3:0]    r_q;
    logic          fin_q;
    block_t        st_q;
    block_t        out_q;
    logic [31:0]   tmp;
    logic [31:0]   w_new;
    logic [127:0]  rk_cur;
    logic [127:0]  rk_last;
    logic [127:0]  rnd_out;
    logic [127:0]  chain;
    logic          key_acc;
    logic          blk_acc;

    always_comb begin
        state_d   = state_q;
        key_ready = (state_q == S_NOKEY) || (state_q == S_IDLE);
        // a pending key change wins over a block offered in the same cycle
        in_ready  = (state_q == S_IDLE) && !key_valid;
        out_valid = (state_q == S_HOLD);
        unique case (state_q)
            S_NOKEY:  if (key_valid) state_d = S_EXPAND;
            S_EXPAND: if (i_q == IW'(NW - 1)) state_d = S_IDLE;
            S_IDLE: begin
                if (key_valid)     state_d = S_EXPAND;
                else if (in_valid) state_d = S_ROUND;
            end
            S_ROUND:  if (fin_q) state_d = S_HOLD;
            S_HOLD:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_NOKEY;
        endcase
    end

    assign key_acc = key_valid && key_ready;
    assign blk_acc = in_valid && in_ready;

    always_comb begin
        tmp = w_q[i_q - IW'(1)];
        if (m_q == 3'd0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(rc_q), 24'h0};
        end else if (NK == 8 && m_q == 3'd4) begin
            tmp = sub_word(tmp);
        end
        w_new = w_q[i_q - IW'(NK)] ^ tmp;
    end

    always_ff @(posedge clk) begin
        if (key_acc) begin
            for (int j = 0; j < NK; j++) begin
                w_q[j] <= key_in[32 * (NK - j) - 1 -: 32];
            end
        end else if (state_q == S_EXPAND) begin
            w_q[i_q] <= w_new;
        end
    end

    assign rk_cur  = {w_q[{r_q, 2'd0}], w_q[{r_q, 2'd1}],
                      w_q[{r_q, 2'd2}], w_q[{r_q, 2'd3}]};
    assign rk_last = {w_q[4 * NR], w_q[4 * NR + 1],
                      w_q[4 * NR + 2], w_q[4 * NR + 3]};

    aes_dec_round u_round (
        .st_i   (st_q),
        .rk_i   (rk_cur),
        .last_i (r_q == 4'd0),
        .st_o   (rnd_out)
    );

    // the chaining XOR gets its own cycle after the last round
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NOKEY;
            i_q     <= '0;
            m_q     <= '0;
            rc_q    <= '0;
            r_q     <= '0;
            fin_q   <= 1'b0;
            st_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (key_acc) begin
                i_q  <= IW'(NK);
                m_q  <= '0;
                rc_q <= 4'd1;
            end else if (state_q == S_EXPAND) begin
                i_q <= i_q + IW'(1);
                m_q <= (m_q == 3'(NK - 1)) ? 3'd0 : m_q + 3'd1;
                if (m_q == 3'd0) rc_q <= rc_q + 4'd1;
            end
            if (blk_acc) begin
                st_q  <= in_data ^ rk_last;
                r_q   <= 4'(NR - 1);
                fin_q <= 1'b0;
            end else if (state_q == S_ROUND) begin
                if (fin_q) begin
                    out_q <= st_q ^ chain;
                    fin_q <= 1'b0;
                end else begin
                    st_q <= rnd_out;
                    if (r_q == 4'd0) fin_q <= 1'b1;
                    else             r_q   <= r_q - 4'd1;
                end
            end
        end
    end

`ifdef AES_DEC_CBC_EN
    logic [127:0] c_q;
    logic [127:0] ct_q;
    logic         cbc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            ct_q  <= '0;
            cbc_q <= 1'b0;
        end else begin
            if (iv_load && key_ready) c_q <= iv_in;
            if (blk_acc) begin
                ct_q  <= in_data;
                cbc_q <= cbc_mode;
            end
            if (out_valid && out_ready && cbc_q) c_q <= ct_q;
        end
    end

    assign chain = cbc_q ? c_q : '0;
`else
    assign chain = '0;
`endif

    assign out_data = out_q;

endmodule
